// File: rtl/dense_serializer.sv
// dense_serializer
//   Captures NUM_TREES signed 32-bit accumulator results in one beat. Each
//   result is requantized to a signed 8-bit pixel using a rounded arithmetic
//   right shift followed by saturation. The pixels are then streamed out one
//   per beat, tree 0 first.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   acc_in       NUM_TREES x 32-bit signed results, tree i at [32*i+31:32*i]
//   load_valid   acc_in valid this cycle
//   load_ready   block can capture acc_in this cycle (combinational)
//   pixel_out    registered signed requantized pixel
//   pixel_valid  registered, pixel_out valid
//   pixel_ready  downstream accepts pixel_out
//   pixel_last   registered, high with the pixel for tree NUM_TREES-1
module dense_serializer #(
    parameter int NUM_TREES = 4,
    parameter int SHIFT     = 8,
    parameter int ROUND_EN  = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [32*NUM_TREES-1:0]   acc_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic [7:0]                pixel_out,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      pixel_last
);

    localparam int IW = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TREES - 1);

    // Half-LSB rounding constant. The shift amount is clamped so that
    // SHIFT=0 never produces a negative shift, even in the unused branch.
    localparam logic signed [33:0] RND =
        (ROUND_EN != 0 && SHIFT > 0) ? (34'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 34'sd0;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q, state_d;
    logic [NUM_TREES-1:0][31:0]    buf_q;
    logic [IW-1:0]                 index;
    logic [IW-1:0]                 next_idx;
    logic                          load_fire;
    logic                          beat_fire;

    // Two guard bits keep x + RND from overflowing at x = 0x7FFFFFFF.
    function automatic logic [7:0] requant(input logic [31:0] x);
        logic signed [33:0] s;
        s = signed'({{2{x[31]}}, x});
        s = s + RND;
        s = s >>> SHIFT;
        if (s > 34'sd127)
            return 8'h7F;
        else if (s < -34'sd128)
            return 8'h80;
        else
            return s[7:0];
    endfunction

    assign load_fire = load_valid && load_ready;
    assign beat_fire = pixel_valid && pixel_ready;
    assign next_idx  = index + IW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // load_ready is also gated by reset so it stays low while reset is held.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = reset;
                if (load_fire)
                    state_d = SEND;
            end
            SEND: begin
                // The last-beat transfer frees the buffer, so a new load can
                // land on that same edge without a bubble.
                load_ready = beat_fire && pixel_last;
                if (beat_fire && pixel_last && !load_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Each pixel is requantized one cycle ahead of presentation, so the
    // outputs come straight from flops and hold steady under backpressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q       <= '0;
            index       <= '0;
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            pixel_last  <= 1'b0;
        end else if (load_fire) begin
            buf_q       <= acc_in;
            index       <= '0;
            pixel_out   <= requant(acc_in[31:0]);
            pixel_valid <= 1'b1;
            pixel_last  <= (NUM_TREES == 1);
        end else if (beat_fire) begin
            if (pixel_last) begin
                pixel_valid <= 1'b0;
                pixel_last  <= 1'b0;
            end else begin
                index       <= next_idx;
                pixel_out   <= requant(buf_q[next_idx]);
                pixel_last  <= (next_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_dense_serializer.sv
module tb_dense_serializer;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] acc_in;
    logic         load_valid, load_ready;
    logic [7:0]   pixel_out;
    logic         pixel_valid, pixel_ready, pixel_last;

    // second instance: truncation, SHIFT=4, two trees
    logic [63:0]  acc_in2;
    logic         load_valid2, load_ready2;
    logic [7:0]   pixel_out2;
    logic         pixel_valid2, pixel_ready2, pixel_last2;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] VEC_A = {32'h00000000, 32'hFFFFFF00, 32'h00000280, 32'h00000100};
    localparam logic [127:0] VEC_S = {32'hFFFF8080, 32'h00007F80, 32'h80000000, 32'h7FFFFFFF};
    localparam logic [127:0] VEC_B = {32'h00000400, 32'h00000300, 32'h00000200, 32'h00000100};

    always #5 clock = ~clock;

    dense_serializer #(.NUM_TREES(4), .SHIFT(8), .ROUND_EN(1)) dut (
        .clock(clock), .reset(reset), .acc_in(acc_in), .load_valid(load_valid),
        .load_ready(load_ready), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .pixel_last(pixel_last)
    );

    dense_serializer #(.NUM_TREES(2), .SHIFT(4), .ROUND_EN(0)) dut_trunc (
        .clock(clock), .reset(reset), .acc_in(acc_in2), .load_valid(load_valid2),
        .load_ready(load_ready2), .pixel_out(pixel_out2), .pixel_valid(pixel_valid2),
        .pixel_ready(pixel_ready2), .pixel_last(pixel_last2)
    );

    task automatic test_reset();
        reset = 1'b0; acc_in = '0; load_valid = 1'b0; pixel_ready = 1'b0;
        acc_in2 = '0; load_valid2 = 1'b0; pixel_ready2 = 1'b0;
        @(negedge clock); #1;
        checks++;
        if (pixel_valid !== 1'b0 || pixel_last !== 1'b0 || pixel_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b p=%h want 0 0 00", pixel_valid, pixel_last, pixel_out);
        end
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_load_ready_held got=%b want=0", load_ready);
        end
        @(negedge clock); reset = 1'b1; #1;
        checks++;
        if (load_ready !== 1'b1 || load_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_load_ready got=%b/%b want=1/1", load_ready, load_ready2);
        end
    endtask

    // Loads vec with pixel_ready held high and checks all four beats.
    task automatic run_stream(input string name, input logic [127:0] vec, input logic [31:0] exp_packed);
        logic [7:0] exp [4];
        for (int i = 0; i < 4; i++) exp[i] = exp_packed[8*i +: 8];
        @(negedge clock); acc_in = vec; load_valid = 1'b1; pixel_ready = 1'b1; #1;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_load_ready_idle got=%b want=1", name, load_ready);
        end
        @(negedge clock); load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== exp[i]) begin
                failures++;
                $display("FAIL %s_pixel%0d got v=%b p=%h want v=1 p=%h", name, i, pixel_valid, pixel_out, exp[i]);
            end
            checks++;
            if (pixel_last !== (i == 3) || load_ready !== (i == 3)) begin
                failures++;
                $display("FAIL %s_last_ready%0d got l=%b r=%b want %b", name, i, pixel_last, load_ready, (i == 3));
            end
            @(negedge clock);
        end
        #1;
        checks++;
        if (pixel_valid !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle_after got v=%b r=%b want v=0 r=1", name, pixel_valid, load_ready);
        end
    endtask

    task automatic test_basic();
        run_stream("basic", VEC_A, {8'h00, 8'hFF, 8'h03, 8'h01});
    endtask

    task automatic test_saturation();
        run_stream("sat", VEC_S, {8'h81, 8'h7F, 8'h80, 8'h7F});
    endtask

    task automatic test_backpressure();
        logic       rdy [7];
        logic [7:0] exp [4];
        int         ptr;
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp = '{8'h01, 8'h02, 8'h03, 8'h04};
        ptr = 0;
        @(negedge clock); acc_in = VEC_B; load_valid = 1'b1; pixel_ready = 1'b0;
        @(negedge clock); load_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            pixel_ready = rdy[c]; #1;
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== exp[ptr] || pixel_last !== (ptr == 3)) begin
                failures++;
                $display("FAIL bp_cycle%0d got v=%b p=%h l=%b want v=1 p=%h l=%b",
                         c, pixel_valid, pixel_out, pixel_last, exp[ptr], (ptr == 3));
            end
            if (rdy[c]) ptr++;
            @(negedge clock);
        end
        pixel_ready = 1'b1; #1;
        checks++;
        if (pixel_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_extra got v=%b want 0", pixel_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8];
        exp = '{8'h01, 8'h03, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h7F, 8'h81};
        @(negedge clock); acc_in = VEC_A; load_valid = 1'b1; pixel_ready = 1'b1;
        @(negedge clock); acc_in = VEC_S;  // ignored until the last-beat transfer
        for (int i = 0; i < 8; i++) begin
            if (i == 4) load_valid = 1'b0;
            #1;
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== exp[i] || pixel_last !== (i == 3 || i == 7)) begin
                failures++;
                $display("FAIL b2b_beat%0d got v=%b p=%h l=%b want v=1 p=%h l=%b",
                         i, pixel_valid, pixel_out, pixel_last, exp[i], (i == 3 || i == 7));
            end
            if (i == 3) begin
                checks++;
                if (load_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_reload_ready got=%b want=1", load_ready);
                end
            end
            @(negedge clock);
        end
        #1;
        checks++;
        if (pixel_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got v=%b want 0", pixel_valid);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clock); acc_in = VEC_A; load_valid = 1'b1; pixel_ready = 1'b1;
        @(negedge clock); load_valid = 1'b0;   // pixel 0 presented
        @(negedge clock);                      // pixel 1 presented
        @(negedge clock);                      // pixel 2 presented, two beats done
        #2; reset = 1'b0; #1;
        checks++;
        if (pixel_valid !== 1'b0 || pixel_last !== 1'b0 || pixel_out !== 8'h00) begin
            failures++;
            $display("FAIL midreset_async got v=%b l=%b p=%h want 0 0 00", pixel_valid, pixel_last, pixel_out);
        end
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_load_ready got=%b want=0", load_ready);
        end
        @(negedge clock); reset = 1'b1; #1;
        checks++;
        if (load_ready !== 1'b1 || pixel_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release got r=%b v=%b want r=1 v=0", load_ready, pixel_valid);
        end
        run_stream("after_reset", VEC_S, {8'h81, 8'h7F, 8'h80, 8'h7F});
    endtask

    task automatic test_truncate();
        @(negedge clock); acc_in2 = {32'hFFFFFFE8, 32'h00000018}; load_valid2 = 1'b1; pixel_ready2 = 1'b1;
        @(negedge clock); load_valid2 = 1'b0; #1;
        checks++;
        if (pixel_valid2 !== 1'b1 || pixel_out2 !== 8'h01 || pixel_last2 !== 1'b0) begin
            failures++;
            $display("FAIL trunc_pixel0 got v=%b p=%h l=%b want v=1 p=01 l=0", pixel_valid2, pixel_out2, pixel_last2);
        end
        @(negedge clock); #1;
        checks++;
        if (pixel_valid2 !== 1'b1 || pixel_out2 !== 8'hFE || pixel_last2 !== 1'b1) begin
            failures++;
            $display("FAIL trunc_pixel1 got v=%b p=%h l=%b want v=1 p=fe l=1", pixel_valid2, pixel_out2, pixel_last2);
        end
        @(negedge clock); #1;
        checks++;
        if (pixel_valid2 !== 1'b0) begin
            failures++;
            $display("FAIL trunc_end got v=%b want 0", pixel_valid2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_truncate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
